// File: rtl/av_pkg.sv
// av_pkg: shared widths and the fade FSM state encoding for the pixel mixer.
package av_pkg;

    localparam int ALPHA_W    = 5;    // alpha spans 0..16 inclusive
    localparam int ALPHA_MAX  = 16;   // fully opaque menu
    localparam int RGB_W      = 12;   // RGB444 pixel
    localparam int CH_W       = 4;    // one colour channel
    localparam int NUM_CH     = 3;    // R, G, B
    localparam int STEP_CNT_W = 4;    // frames-per-step counter, holds up to 15

    typedef enum logic [1:0] {
        AV_IDLE     = 2'd0,
        AV_FADE_IN  = 2'd1,
        AV_SHOWN    = 2'd2,
        AV_FADE_OUT = 2'd3
    } av_state_e;

endpackage

// File: rtl/av_sync_delay.sv
// av_sync_delay: per-lane shift-register delay for the sync/blank bundle.
// Every lane is DEPTH stages long and resets to 1 (inactive sync, blanked).
// LSB_LEAD shortens lane 0 by that many stages so a consumer that registers
// its own output can use lane 0 (blank) one stage early and still land aligned.
module av_sync_delay #(
    parameter int DEPTH    = 3,
    parameter int WIDTH    = 3,
    parameter int LSB_LEAD = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sync,
    output logic [WIDTH-1:0] o_sync
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            localparam int LEN = (gi == 0) ? (DEPTH - LSB_LEAD) : DEPTH;

            logic [LEN-1:0] r_shift;

            // Shift the lane by one stage per clock; reset fills it with ones.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_shift <= '1;
                end else begin
                    r_shift <= LEN'({r_shift, i_sync[gi]});
                end
            end

            assign o_sync[gi] = r_shift[LEN-1];
        end
    endgenerate

endmodule

// File: rtl/av_pixel_mixer.sv
// av_pixel_mixer: blends the layered menu pixel over the game pixel with a
// frame-stepped fade alpha, then drives registered VGA colour and syncs.
// Colour path latency is 2 clocks; syncs are delayed IN_LAG+2 clocks to match.
// Optional build macro AV_MIXER_DIM_EN: non-opaque game pixels are darkened
// by alpha (down to half brightness at alpha=16) instead of passing through.
module av_pixel_mixer
    import av_pkg::*;
#(
    parameter int IN_LAG      = 1,
    parameter int STEP_FRAMES = 2
) (
    input  logic             clk65,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             blank,
    input  logic             menu_active,
    input  logic [RGB_W:0]   menu_pixel,
    input  logic [RGB_W-1:0] game_pixel,
    output logic [CH_W-1:0]  vga_r,
    output logic [CH_W-1:0]  vga_g,
    output logic [CH_W-1:0]  vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             fade_busy
);

    av_state_e             r_state;
    av_state_e             w_state_next;
    logic [ALPHA_W-1:0]    r_alpha;
    logic [ALPHA_W-1:0]    w_alpha_next;
    logic [ALPHA_W-1:0]    r_alpha_frame;
    logic [ALPHA_W-1:0]    w_alpha_inv;
    logic [STEP_CNT_W-1:0] r_step_cnt;
    logic [STEP_CNT_W-1:0] w_step_cnt_next;
    logic                  r_vs_prev;
    logic                  w_frame_tick;
    logic                  w_step_tick;
    logic                  r_opaque;
    logic [2:0]            w_sync_d;
    logic                  w_blank_early;
    logic [RGB_W-1:0]      w_rgb;

    // Remember last vsync so its falling edge yields a one-cycle frame tick.
    always_ff @(posedge clk65 or posedge reset) begin
        if (reset) begin
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_prev <= vsync;
        end
    end

    assign w_frame_tick = r_vs_prev & ~vsync;
    assign w_step_tick  = w_frame_tick && (r_step_cnt == STEP_CNT_W'(STEP_FRAMES - 1));

    // Fade state, alpha and frame counter; alpha snapshot is refreshed only at
    // the frame tick so the colour pipeline sees one alpha per frame.
    always_ff @(posedge clk65 or posedge reset) begin
        if (reset) begin
            r_state       <= AV_IDLE;
            r_alpha       <= '0;
            r_step_cnt    <= '0;
            r_alpha_frame <= '0;
        end else begin
            r_state    <= w_state_next;
            r_alpha    <= w_alpha_next;
            r_step_cnt <= w_step_cnt_next;
            if (w_frame_tick) begin
                r_alpha_frame <= w_alpha_next;
            end
        end
    end

    // Next-state logic: counter advances on frame ticks, the FSM moves only on
    // step ticks. Leaving IDLE/SHOWN changes alpha in the same step; reversing
    // direction mid-fade holds alpha for that step.
    always_comb begin
        w_state_next    = r_state;
        w_alpha_next    = r_alpha;
        w_step_cnt_next = r_step_cnt;
        if (w_frame_tick) begin
            w_step_cnt_next = w_step_tick ? '0 : r_step_cnt + STEP_CNT_W'(1);
        end
        if (w_step_tick) begin
            case (r_state)
                AV_IDLE: begin
                    if (menu_active) begin
                        w_state_next = AV_FADE_IN;
                        w_alpha_next = ALPHA_W'(1);
                    end
                end
                AV_FADE_IN: begin
                    if (!menu_active) begin
                        w_state_next = AV_FADE_OUT;
                    end else if (r_alpha >= ALPHA_W'(ALPHA_MAX - 1)) begin
                        w_state_next    = AV_SHOWN;
                        w_alpha_next    = ALPHA_W'(ALPHA_MAX);
                        w_step_cnt_next = '0;
                    end else begin
                        w_alpha_next = r_alpha + ALPHA_W'(1);
                    end
                end
                AV_SHOWN: begin
                    if (!menu_active) begin
                        w_state_next = AV_FADE_OUT;
                        w_alpha_next = r_alpha - ALPHA_W'(1);
                    end
                end
                AV_FADE_OUT: begin
                    if (menu_active) begin
                        w_state_next = AV_FADE_IN;
                    end else if (r_alpha <= ALPHA_W'(1)) begin
                        w_state_next    = AV_IDLE;
                        w_alpha_next    = '0;
                        w_step_cnt_next = '0;
                    end else begin
                        w_alpha_next = r_alpha - ALPHA_W'(1);
                    end
                end
                default: begin
                    w_state_next = AV_IDLE;
                    w_alpha_next = '0;
                end
            endcase
        end
    end

    assign fade_busy   = (r_state == AV_FADE_IN) || (r_state == AV_FADE_OUT);
    assign w_alpha_inv = ALPHA_W'(ALPHA_MAX) - r_alpha_frame;

    // Stage 1 carries the opaque flag alongside the channel products.
    always_ff @(posedge clk65 or posedge reset) begin
        if (reset) begin
            r_opaque <= 1'b0;
        end else begin
            r_opaque <= menu_pixel[RGB_W];
        end
    end

    // Blank lane comes out one stage early so it can gate the stage-2 register.
    av_sync_delay #(
        .DEPTH    (IN_LAG + 2),
        .WIDTH    (3),
        .LSB_LEAD (1)
    ) u_sync_delay (
        .i_clk  (clk65),
        .i_rst  (reset),
        .i_sync ({hsync, vsync, blank}),
        .o_sync (w_sync_d)
    );

    assign vga_hs        = w_sync_d[2];
    assign vga_vs        = w_sync_d[1];
    assign w_blank_early = w_sync_d[0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CH_W-1:0] w_m;
            logic [CH_W-1:0] w_g;
            logic [7:0]      r_prod_m;
            logic [7:0]      r_prod_g;
            logic [CH_W-1:0] r_g;
            logic [CH_W-1:0] r_out;
`ifdef AV_MIXER_DIM_EN
            logic [7:0]      r_prod_d;
`endif

            assign w_m = menu_pixel[gi*CH_W +: CH_W];
            assign w_g = game_pixel[gi*CH_W +: CH_W];

            // Stage 1: weighted products; each fits 8 bits (15*16 = 240).
            always_ff @(posedge clk65 or posedge reset) begin
                if (reset) begin
                    r_prod_m <= '0;
                    r_prod_g <= '0;
                    r_g      <= '0;
`ifdef AV_MIXER_DIM_EN
                    r_prod_d <= '0;
`endif
                end else begin
                    r_prod_m <= {4'b0, w_m} * {3'b0, r_alpha_frame};
                    r_prod_g <= {4'b0, w_g} * {3'b0, w_alpha_inv};
                    r_g      <= w_g;
`ifdef AV_MIXER_DIM_EN
                    r_prod_d <= {4'b0, w_g} * {3'b0, r_alpha_frame};
`endif
                end
            end

            // Stage 2: truncating blend for opaque menu pixels, game colour
            // otherwise; blanking overrides everything.
            always_ff @(posedge clk65 or posedge reset) begin
                if (reset) begin
                    r_out <= '0;
                end else if (w_blank_early) begin
                    r_out <= '0;
                end else if (r_opaque) begin
                    r_out <= CH_W'((r_prod_m + r_prod_g) >> 4);
                end else begin
`ifdef AV_MIXER_DIM_EN
                    r_out <= r_g - CH_W'(r_prod_d >> 5);
`else
                    r_out <= r_g;
`endif
                end
            end

            assign w_rgb[gi*CH_W +: CH_W] = r_out;
        end
    endgenerate

    assign vga_r = w_rgb[11:8];
    assign vga_g = w_rgb[7:4];
    assign vga_b = w_rgb[3:0];

endmodule

// File: tb/tb_av_pixel_mixer.sv
// tb_av_pixel_mixer: directed scoreboard bench for av_pixel_mixer
// (IN_LAG=1, STEP_FRAMES=2). Colour expectations are queued 2 steps ahead,
// sync expectations 3 steps ahead, and popped as the DUT produces them.
module tb_av_pixel_mixer;
    import av_pkg::*;

    logic        clk65       = 1'b0;
    logic        reset       = 1'b0;
    logic        hsync       = 1'b1;
    logic        vsync       = 1'b1;
    logic        blank       = 1'b1;
    logic        menu_active = 1'b0;
    logic [12:0] menu_pixel  = '0;
    logic [11:0] game_pixel  = '0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, fade_busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_step  = 0;
    logic [11:0] q_pix[$];
    logic [1:0]  q_sync[$];
    logic        prev_bl = 1'b1;

    av_pixel_mixer #(
        .IN_LAG      (1),
        .STEP_FRAMES (2)
    ) dut (
        .clk65       (clk65),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .menu_active (menu_active),
        .menu_pixel  (menu_pixel),
        .game_pixel  (game_pixel),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .fade_busy   (fade_busy)
    );

    always #8 clk65 = ~clk65;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference mix: c = (m*a + g*(16-a)) >> 4 for opaque pixels.
    function automatic logic [11:0] model_mix(input logic [12:0] mp, input logic [11:0] gp, input int a);
        logic [11:0] res;
        int m, g, c;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            m = int'(mp[4*ch +: 4]);
            g = int'(gp[4*ch +: 4]);
            if (mp[12]) begin
                c = (m * a + g * (16 - a)) >> 4;
            end else begin
`ifdef AV_MIXER_DIM_EN
                c = g - ((g * a) >> 5);
`else
                c = g;
`endif
            end
            res[4*ch +: 4] = 4'(c);
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare due outputs, then drive the next inputs and queue
    // their expectations. The pixel belongs to the blank driven one step earlier.
    task automatic step(input logic hs, input logic vs, input logic bl, input logic ma,
                        input logic [12:0] mp, input logic [11:0] gp, input int a);
        logic [11:0] exp_pix;
        logic [1:0]  exp_sync;
        @(posedge clk65);
        #1;
        n_step++;
        exp_pix  = q_pix.pop_front();
        exp_sync = q_sync.pop_front();
        check($sformatf("rgb@%0d", n_step), {4'h0, vga_r, vga_g, vga_b}, {4'h0, exp_pix});
        check($sformatf("hs_vs@%0d", n_step), {14'h0, vga_hs, vga_vs}, {14'h0, exp_sync});
        hsync       = hs;
        vsync       = vs;
        blank       = bl;
        menu_active = ma;
        menu_pixel  = mp;
        game_pixel  = gp;
        q_pix.push_back(prev_bl ? 12'h000 : model_mix(mp, gp, a));
        q_sync.push_back({hs, vs});
        prev_bl = bl;
    endtask

    // A short blanked frame: vsync low for two clocks gives one frame tick.
    task automatic frame(input logic ma);
        repeat (2) step(1'b1, 1'b0, 1'b1, ma, 13'h0000, 12'h000, 0);
        repeat (2) step(1'b1, 1'b1, 1'b1, ma, 13'h0000, 12'h000, 0);
    endtask

    // Raise reset mid-cycle, check async and post-edge state, release at negedge.
    task automatic apply_reset(input string tag);
        #3;
        reset       = 1'b1;
        hsync       = 1'b1;
        vsync       = 1'b1;
        blank       = 1'b1;
        menu_active = 1'b0;
        menu_pixel  = '0;
        game_pixel  = '0;
        #1;
        check({tag, "_async"}, {2'b00, vga_hs, vga_vs, vga_r, vga_g, vga_b}, 16'h3000);
        @(posedge clk65);
        #1;
        check({tag, "_edge"}, {2'b00, vga_hs, vga_vs, vga_r, vga_g, vga_b}, 16'h3000);
        check({tag, "_alpha"}, {11'h0, dut.r_alpha}, 16'h0000);
        check({tag, "_state"}, {14'h0, dut.r_state}, {14'h0, AV_IDLE});
        check({tag, "_busy"}, {15'h0, fade_busy}, 16'h0000);
        @(negedge clk65);
        reset = 1'b0;
        q_pix.delete();
        q_sync.delete();
        repeat (2) q_pix.push_back(12'h000);
        repeat (3) q_sync.push_back(2'b11);
        prev_bl = 1'b1;
    endtask

    initial begin
        // Power-up reset, then some activity, then reset again mid-frame.
        apply_reset("rst0");
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 13'h0000, 12'h123, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 13'h1FFF, 12'h456, 0);
        apply_reset("rst_mid");

        // Alignment: game colour passes through, hsync delayed 3 clocks.
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 13'h0F00, 12'hA5C, 0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 13'h0F00, 12'hA5C, 0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 13'h0F00, 12'hA5C, 0);

        // Fade in: alpha climbs one per two frames, busy while fading.
        for (int n = 1; n <= 32; n++) begin
            frame(1'b1);
            check($sformatf("fin_alpha_f%0d", n), {11'h0, dut.r_alpha}, 16'(n / 2));
            check($sformatf("fin_busy_f%0d", n), {15'h0, fade_busy}, {15'h0, (n >= 2 && n < 32)});
        end
        check("fin_state", {14'h0, dut.r_state}, {14'h0, AV_SHOWN});
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 13'h1DDD, 12'h000, 16);

        // Full fade out back to idle.
        for (int n = 1; n <= 32; n++) begin
            frame(1'b0);
            check($sformatf("fout_alpha_f%0d", n), {11'h0, dut.r_alpha}, 16'(16 - n / 2));
        end
        check("fout_state", {14'h0, dut.r_state}, {14'h0, AV_IDLE});
        check("fout_busy", {15'h0, fade_busy}, 16'h0000);

        // Fade in to alpha 8.
        for (int n = 1; n <= 16; n++) frame(1'b1);
        check("half_alpha", {11'h0, dut.r_alpha}, 16'd8);
        check("half_state", {14'h0, dut.r_state}, {14'h0, AV_FADE_IN});

        // Blend at alpha 8, including a blanked pixel and a non-opaque one.
        step(1'b1, 1'b1, 1'b0, 1'b1, 13'h1FFF, 12'h000, 8);
        step(1'b1, 1'b1, 1'b0, 1'b1, 13'h1FFF, 12'h000, 8);
        step(1'b1, 1'b1, 1'b0, 1'b1, 13'h1A5C, 12'h36F, 8);
        step(1'b1, 1'b1, 1'b1, 1'b1, 13'h1FFF, 12'h000, 8);
        step(1'b1, 1'b1, 1'b0, 1'b1, 13'h1FFF, 12'h000, 8);
        step(1'b1, 1'b1, 1'b0, 1'b1, 13'h0FFF, 12'hEEE, 8);
        step(1'b1, 1'b1, 1'b0, 1'b1, 13'h1FFF, 12'h000, 8);

        // Reverse mid-fade: first step holds alpha, then it decrements to 0.
        frame(1'b0);
        frame(1'b0);
        check("rev_hold_alpha", {11'h0, dut.r_alpha}, 16'd8);
        check("rev_state", {14'h0, dut.r_state}, {14'h0, AV_FADE_OUT});
        check("rev_busy", {15'h0, fade_busy}, 16'h0001);
        for (int k = 1; k <= 8; k++) begin
            frame(1'b0);
            frame(1'b0);
            check($sformatf("rev_alpha_s%0d", k), {11'h0, dut.r_alpha}, 16'(8 - k));
        end
        check("rev_end_state", {14'h0, dut.r_state}, {14'h0, AV_IDLE});

        // Alpha 16 again: non-opaque pixel is dimmed only with the build option.
        for (int n = 1; n <= 32; n++) frame(1'b1);
        check("full_alpha", {11'h0, dut.r_alpha}, 16'd16);
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1, 13'h0FFF, 12'hEEE, 16);
        step(1'b1, 1'b1, 1'b0, 1'b1, 13'h1DDD, 12'h000, 16);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 13'h0000, 12'h000, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
